// File: rtl/l1_line_fill_responder_pkg.sv
// Shared types for the L1 line-fill responder: FSM state encoding and burst counter width.
package l1_line_fill_responder_pkg;

   localparam int L1_MAX_BURST_W = 6;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_DRAIN,
      WR,
      INV
   } l1_resp_state_t;

   // size+1 is a power of two, so size itself is the mask of the in-line word offset.
   function automatic logic [29:0] line_base(input logic [29:0] word_addr, input logic [4:0] size);
      return word_addr & ~{25'd0, size};
   endfunction

endpackage

// File: rtl/l1_arbiter_interfaces.sv
// L1 arbiter request and return interfaces; the responder uses the slave modports.
interface l1_arbiter_request_interface;
   logic        request;
   logic [31:0] addr;
   logic        rnw;
   logic [3:0]  be;
   logic [31:0] data;
   logic [4:0]  size;
   logic        ack;

   modport master (output request, addr, rnw, be, data, size, input ack);
   modport slave  (input request, addr, rnw, be, data, size, output ack);
endinterface

interface l1_arbiter_return_interface;
   logic        data_valid;
   logic [31:0] data;
   logic        inv_valid;
   logic [29:0] inv_addr;
   logic        inv_ack;

   modport master (input data_valid, data, inv_valid, inv_addr, output inv_ack);
   modport slave  (output data_valid, data, inv_valid, inv_addr, input inv_ack);
endinterface

// File: rtl/l1_line_fill_responder.sv
// Responder for L1 line fills and single-word writes over a pipelined word memory port.
// Write invalidation toward the requester is built in when L1_RESP_INV_EN is defined.
module l1_line_fill_responder
   import l1_line_fill_responder_pkg::*;
#(
   parameter int MEM_LATENCY_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   l1_arbiter_request_interface.slave l1_request,
   l1_arbiter_return_interface.slave  l1_response,
   output logic        mem_req,
   output logic [29:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam int INFLIGHT_W = $clog2(MEM_LATENCY_MAX + 1);
   localparam logic [INFLIGHT_W-1:0] INFLIGHT_FULL = INFLIGHT_W'(MEM_LATENCY_MAX);

   l1_resp_state_t            state_reg;
   logic [29:0]               addr_reg;
   logic [3:0]                be_reg;
   logic [31:0]               data_reg;
   logic [4:0]                size_reg;
   logic [L1_MAX_BURST_W-1:0] issue_cnt_reg;
   logic [L1_MAX_BURST_W-1:0] ret_cnt_reg;
   logic [INFLIGHT_W-1:0]     inflight_reg;
   logic                      data_valid_reg;
   logic [31:0]               rdata_reg;

   logic [L1_MAX_BURST_W-1:0] burst_len;
   logic [L1_MAX_BURST_W-1:0] ret_cnt_next;
   logic [29:0]               base_addr;
   logic                      in_burst;
   logic                      rd_grant;
   logic                      ret_fire;
   logic                      unused_in;

   assign burst_len    = {1'b0, size_reg} + L1_MAX_BURST_W'(1);
   assign base_addr    = line_base(addr_reg, size_reg);
   assign in_burst     = (state_reg == RD_ISSUE) || (state_reg == RD_DRAIN);
   // Returns outside a read burst (e.g. leftovers from before a reset) are dropped here.
   assign ret_fire     = in_burst && mem_rvalid;
   assign rd_grant     = (state_reg == RD_ISSUE) && mem_req && mem_gnt;
   assign ret_cnt_next = ret_cnt_reg + L1_MAX_BURST_W'(ret_fire);

   assign l1_request.ack = !rst && (state_reg == IDLE) && l1_request.request;

   assign mem_req = ((state_reg == RD_ISSUE) && (inflight_reg != INFLIGHT_FULL)) ||
                    (state_reg == WR);
   assign mem_we  = (state_reg == WR);

   always_comb begin
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      case (state_reg)
         RD_ISSUE: mem_addr = base_addr | 30'(issue_cnt_reg);
         WR: begin
            mem_addr  = addr_reg;
            mem_be    = be_reg;
            mem_wdata = data_reg;
         end
         default: ;
      endcase
   end

   assign l1_response.data_valid = data_valid_reg;
   assign l1_response.data       = rdata_reg;

`ifdef L1_RESP_INV_EN
   assign l1_response.inv_valid = (state_reg == INV);
   assign l1_response.inv_addr  = (state_reg == INV) ? addr_reg : '0;
   assign unused_in             = ^l1_request.addr[1:0];
`else
   assign l1_response.inv_valid = 1'b0;
   assign l1_response.inv_addr  = '0;
   assign unused_in             = ^{l1_request.addr[1:0], l1_response.inv_ack};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         addr_reg       <= '0;
         be_reg         <= '0;
         data_reg       <= '0;
         size_reg       <= '0;
         issue_cnt_reg  <= '0;
         ret_cnt_reg    <= '0;
         inflight_reg   <= '0;
         data_valid_reg <= 1'b0;
         rdata_reg      <= '0;
      end else begin
         data_valid_reg <= ret_fire;
         if (ret_fire) begin
            rdata_reg   <= mem_rdata;
            ret_cnt_reg <= ret_cnt_next;
         end

         case ({rd_grant, ret_fire})
            2'b10:   inflight_reg <= inflight_reg + INFLIGHT_W'(1);
            2'b01:   inflight_reg <= inflight_reg - INFLIGHT_W'(1);
            default: ;
         endcase

         case (state_reg)
            IDLE: begin
               if (l1_request.request) begin
                  addr_reg      <= l1_request.addr[31:2];
                  be_reg        <= l1_request.be;
                  data_reg      <= l1_request.data;
                  size_reg      <= l1_request.size;
                  issue_cnt_reg <= '0;
                  ret_cnt_reg   <= '0;
                  state_reg     <= l1_request.rnw ? RD_ISSUE : WR;
               end
            end
            RD_ISSUE: begin
               if (rd_grant) begin
                  issue_cnt_reg <= issue_cnt_reg + L1_MAX_BURST_W'(1);
                  if (issue_cnt_reg + L1_MAX_BURST_W'(1) == burst_len) begin
                     state_reg <= RD_DRAIN;
                  end
               end
            end
            RD_DRAIN: begin
               if (ret_cnt_next == burst_len) begin
                  state_reg <= IDLE;
               end
            end
            WR: begin
               if (mem_gnt) begin
`ifdef L1_RESP_INV_EN
                  state_reg <= INV;
`else
                  state_reg <= IDLE;
`endif
               end
            end
`ifdef L1_RESP_INV_EN
            INV: begin
               if (l1_response.inv_ack) begin
                  state_reg <= IDLE;
               end
            end
`endif
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l1_line_fill_responder.sv
// Bench for l1_line_fill_responder: directed and random line reads/writes against a memory model.
`timescale 1ns/1ps
module tb_l1_line_fill_responder;

   localparam int MAXF = 4;

   typedef struct {
      int          due;
      int          ep;
      logic [31:0] data;
   } ret_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata, mem_rdata;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   int          lat       = 1;
   int          gnt_mode  = 0;
   int          epoch     = 0;
   int          last_due  = 0;
   logic [31:0] seed;
   bit          prev_rv_cur = 1'b0;
   logic [31:0] prev_rdata  = '0;

   ret_t        rq[$];
   logic [31:0] wmem[logic [29:0]];
   logic [31:0] beats[$];
   int          beat_cyc[$];
   int          ack_cyc[$];
   int          inv_cyc[$];
   logic [29:0] grant_addr[$];
   int          grant_cyc[$];
   logic [29:0] wr_addr[$];
   logic [3:0]  wr_be[$];
   logic [31:0] wr_data[$];

   l1_arbiter_request_interface req_if();
   l1_arbiter_return_interface  ret_if();

   l1_line_fill_responder #(.MEM_LATENCY_MAX(MAXF)) dut (
      .clk        (clk),
      .rst        (rst),
      .l1_request (req_if),
      .l1_response(ret_if),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [29:0] w);
      if (wmem.exists(w)) return wmem[w];
      return ({2'b00, w} * 32'h9E37_79B1) ^ seed;
   endfunction

   // Memory model and output monitor; everything sampled at the falling edge.
   always @(negedge clk) begin
      ret_t        r;
      int          n_cur;
      int          due;
      bit          g;
      logic [31:0] w;
      if (ret_if.data_valid === 1'b1 || prev_rv_cur) begin
         check("dv_timing", ret_if.data_valid, prev_rv_cur);
         if (prev_rv_cur) check("dv_data", ret_if.data, prev_rdata);
      end
      if (ret_if.data_valid === 1'b1) begin
         beats.push_back(ret_if.data);
         beat_cyc.push_back(cyc);
      end
      if (req_if.ack === 1'b1) ack_cyc.push_back(cyc);
      if (ret_if.inv_valid === 1'b1) inv_cyc.push_back(cyc);

      mem_rvalid  = 1'b0;
      mem_rdata   = '0;
      prev_rv_cur = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         r           = rq.pop_front();
         mem_rvalid  = 1'b1;
         mem_rdata   = r.data;
         prev_rv_cur = (r.ep == epoch) && !rst;
         prev_rdata  = r.data;
      end

      case (gnt_mode)
         0:       g = 1'b1;
         1:       g = (cyc % 2 == 0);
         default: g = 1'($urandom_range(0, 1));
      endcase
      mem_gnt = g;
      if (mem_req === 1'b1 && g) begin
         if (mem_we === 1'b1) begin
            if (!rst) begin
               wr_addr.push_back(mem_addr);
               wr_be.push_back(mem_be);
               wr_data.push_back(mem_wdata);
               w = mem_rd(mem_addr);
               for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
               wmem[mem_addr] = w;
            end
         end else begin
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            r.due  = due;
            r.ep   = rst ? -1 : epoch;
            r.data = mem_rd(mem_addr);
            rq.push_back(r);
            if (!rst) begin
               grant_addr.push_back(mem_addr);
               grant_cyc.push_back(cyc);
               n_cur = 0;
               for (int i = 0; i < rq.size(); i++) if (rq[i].ep == epoch) n_cur++;
               check("inflight_max", 32'(n_cur <= MAXF), 32'd1);
            end
         end
      end
   end

   task automatic clear_logs();
      beats.delete();
      beat_cyc.delete();
      ack_cyc.delete();
      inv_cyc.delete();
      grant_addr.delete();
      grant_cyc.delete();
      wr_addr.delete();
      wr_be.delete();
      wr_data.delete();
   endtask

   task automatic check_beats(input logic [29:0] base, input int len, input int offs, input string tag);
      for (int i = 0; i < len; i++) begin
         if (offs + i < beats.size()) check({tag, "_beat"}, beats[offs + i], mem_rd(base + 30'(i)));
         if (offs + i < grant_addr.size()) check({tag, "_gaddr"}, grant_addr[offs + i], base + 30'(i));
      end
   endtask

   task automatic wait_ack(input int n);
      int t = 0;
      while (ack_cyc.size() < n && t < 100) begin
         @(posedge clk);
         t++;
      end
   endtask

   task automatic wait_beats(input int n);
      int t = 0;
      while (beats.size() < n && t < 3000) begin
         @(posedge clk);
         t++;
      end
   endtask

   task automatic run_read(input logic [31:0] a, input logic [4:0] sz, input int l, input int gm,
                           input string tag, input bit exact);
      int          len;
      logic [29:0] base;
      len  = int'(sz) + 1;
      base = a[31:2] & ~{25'd0, sz};
      lat = l;
      gnt_mode = gm;
      clear_logs();
      req_if.request = 1'b1;
      req_if.addr    = a;
      req_if.rnw     = 1'b1;
      req_if.size    = sz;
      req_if.be      = 4'hF;
      req_if.data    = $urandom;
      wait_ack(1);
      #1 req_if.request = 1'b0;
      wait_beats(len);
      repeat (l + 4) @(posedge clk);
      #1;
      check({tag, "_acks"}, ack_cyc.size(), 1);
      check({tag, "_nbeats"}, beats.size(), len);
      check({tag, "_ngrants"}, grant_addr.size(), len);
      check({tag, "_idle_req"}, mem_req, 1'b0);
      check_beats(base, len, 0, tag);
      if (exact && ack_cyc.size() > 0 && grant_cyc.size() == len && beat_cyc.size() == len) begin
         for (int i = 0; i < len; i++) check({tag, "_gcyc"}, grant_cyc[i], ack_cyc[0] + 1 + i);
         check({tag, "_first_beat"}, beat_cyc[0], ack_cyc[0] + 3);
         check({tag, "_last_beat"}, beat_cyc[len - 1], ack_cyc[0] + 2 + len);
      end
      $display("[TB] read %s addr=%h size=%0d lat=%0d gnt=%0d beats=%0d", tag, a, sz, l, gm, beats.size());
   endtask

   task automatic run_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                            input int gm, input string tag);
      int t;
      gnt_mode = gm;
      clear_logs();
      req_if.request = 1'b1;
      req_if.addr    = a;
      req_if.rnw     = 1'b0;
      req_if.size    = 5'd0;
      req_if.be      = be;
      req_if.data    = d;
      wait_ack(1);
      #1 req_if.request = 1'b0;
      t = 0;
      while (wr_addr.size() == 0 && t < 50) begin
         @(posedge clk);
         t++;
      end
      #1;
      check({tag, "_nwrites"}, wr_addr.size(), 1);
      if (wr_addr.size() > 0) begin
         check({tag, "_waddr"}, wr_addr[0], a[31:2]);
         check({tag, "_wbe"}, wr_be[0], be);
         check({tag, "_wdata"}, wr_data[0], d);
      end
      check({tag, "_no_rd_grant"}, grant_addr.size(), 0);
`ifdef L1_RESP_INV_EN
      t = 0;
      while (inv_cyc.size() == 0 && t < 20) begin
         @(posedge clk);
         t++;
      end
      #1;
      req_if.request = 1'b1;
      req_if.rnw     = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check({tag, "_inv_valid"}, ret_if.inv_valid, 1'b1);
      check({tag, "_inv_addr"}, ret_if.inv_addr, a[31:2]);
      check({tag, "_inv_blocks_ack"}, ack_cyc.size(), 1);
      ret_if.inv_ack = 1'b1;
      @(posedge clk);
      #1 ret_if.inv_ack = 1'b0;
      wait_ack(2);
      #1 req_if.request = 1'b0;
      wait_beats(1);
      repeat (8) @(posedge clk);
      #1;
      check({tag, "_inv_done"}, ret_if.inv_valid, 1'b0);
      check({tag, "_readback_n"}, beats.size(), 1);
      if (beats.size() > 0) check({tag, "_readback"}, beats[0], mem_rd(a[31:2]));
`else
      repeat (4) @(posedge clk);
      #1;
      check({tag, "_no_inv"}, inv_cyc.size(), 0);
      check({tag, "_inv_addr0"}, ret_if.inv_addr, 30'd0);
      check({tag, "_no_beats"}, beats.size(), 0);
`endif
      $display("[TB] write %s addr=%h be=%b data=%h", tag, a, be, d);
   endtask

   initial begin
      int          n_rst;
      logic [31:0] ra;
      seed = $urandom;
      ret_if.inv_ack = 1'b0;
      req_if.request = 1'b1;
      req_if.addr    = 32'h1000_0014;
      req_if.rnw     = 1'b1;
      req_if.be      = 4'hF;
      req_if.data    = '0;
      req_if.size    = 5'd7;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", req_if.ack, 1'b0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 30'd0);
      check("rst_mem_be", mem_be, 4'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_dv", ret_if.data_valid, 1'b0);
      check("rst_data", ret_if.data, 32'd0);
      check("rst_inv_valid", ret_if.inv_valid, 1'b0);
      check("rst_inv_addr", ret_if.inv_addr, 30'd0);
      req_if.request = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_read(32'h1000_0014, 5'd7, 1, 0, "line_lat1", 1'b1);
      run_read(32'h1000_0014, 5'd7, 3, 1, "line_toggle", 1'b0);
      run_write(32'h2000_0008, 4'b0011, 32'hDEAD_BEEF, 0, "write");

      // Back-to-back reads with request held high throughout.
      lat = 1;
      gnt_mode = 0;
      clear_logs();
      req_if.request = 1'b1;
      req_if.addr    = 32'h3000_0040;
      req_if.rnw     = 1'b1;
      req_if.size    = 5'd7;
      wait_ack(1);
      #1 req_if.addr = 32'h3000_1000;
      wait_ack(2);
      #1 req_if.request = 1'b0;
      wait_beats(16);
      repeat (5) @(posedge clk);
      #1;
      check("b2b_acks", ack_cyc.size(), 2);
      check("b2b_nbeats", beats.size(), 16);
      if (ack_cyc.size() >= 2 && beat_cyc.size() >= 8)
         check("b2b_ack_after_burst", 32'(ack_cyc[1] >= beat_cyc[7]), 32'd1);
      check_beats(32'h3000_0040 >> 2, 8, 0, "b2b_first");
      check_beats(32'h3000_1000 >> 2, 8, 8, "b2b_second");
      $display("[TB] read b2b acks=%0d beats=%0d", ack_cyc.size(), beats.size());

      // Reset in the middle of a burst, with older returns still in the memory pipe.
      lat = 3;
      gnt_mode = 1;
      clear_logs();
      req_if.request = 1'b1;
      req_if.addr    = 32'h1000_0014;
      req_if.rnw     = 1'b1;
      req_if.size    = 5'd7;
      wait_ack(1);
      #1 req_if.request = 1'b0;
      wait_beats(3);
      #1;
      rst = 1'b1;
      epoch++;
      @(negedge clk);
      n_rst = beats.size();
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("rst_mid_no_beats", beats.size(), n_rst);
      check("rst_mid_partial", 32'(n_rst >= 3 && n_rst < 8), 32'd1);
      check("rst_mid_idle", mem_req, 1'b0);
      $display("[TB] reset mid-burst beats_before=%0d", n_rst);
      run_read(32'h1000_0014, 5'd7, 1, 0, "post_rst", 1'b1);

      run_read(32'h0000_0004, 5'd0, 1, 0, "size0", 1'b1);
      check("size0_word1", (grant_addr.size() > 0) ? 32'(grant_addr[0]) : 32'hFFFF_FFFF, 32'd1);

      for (int k = 0; k < 14; k++) begin
         ra = $urandom;
         if ($urandom_range(0, 3) == 0)
            run_write(ra, 4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 2), "rnd_wr");
         else
            run_read(ra, 5'((1 << $urandom_range(0, 5)) - 1), $urandom_range(1, 6),
                     $urandom_range(0, 2), "rnd_rd", 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
      $fatal(1, "watchdog");
   end

endmodule
